// File: rtl/pq_sorted_array.sv
// Sorted-array priority queue: keys held ascending in registers, head (minimum) on dout.
// Each accepted enq/deq/replace takes one busy cycle; new commands are ignored while busy.
module pq_sorted_array #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       busy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       unf
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [DEPTH-1:0][WIDTH-1:0] arr_t;
    typedef enum logic [1:0] {StIdle, StIns, StPop, StRep} state_t;

    state_t           state_q, state_d;
    arr_t             arr_q, arr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Slot i takes the new key or its left neighbour once entry[i] > k or i is past the end;
    // keeping entries equal to k in place makes ties FIFO-ordered.
    function automatic arr_t insert_key(arr_t a, logic [CW-1:0] n, logic [WIDTH-1:0] k);
        logic [DEPTH-1:0] pos;
        arr_t             r;
        for (int i = 0; i < DEPTH; i++) begin
            pos[i] = (i >= int'(n)) || (a[i] > k);
        end
        r[0] = pos[0] ? k : a[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (!pos[i]) begin
                r[i] = a[i];
            end else if (pos[i-1]) begin
                r[i] = a[i-1];
            end else begin
                r[i] = k;
            end
        end
        return r;
    endfunction

    function automatic arr_t pop_head(arr_t a);
        arr_t r;
        for (int i = 0; i < DEPTH - 1; i++) begin
            r[i] = a[i+1];
        end
        r[DEPTH-1] = '0;
        return r;
    endfunction

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign busy  = (state_q != StIdle);
    assign dout  = arr_q[0];
    assign count = cnt_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    always_comb begin
        state_d = state_q;
        arr_d   = arr_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (enq && deq && !empty) begin
                    key_d   = din;
                    state_d = StRep;
                end else if (enq && !full) begin
                    // Also covers enq+deq on an empty queue.
                    key_d   = din;
                    state_d = StIns;
                end else if (enq) begin
                    ovf_d = 1'b1;
                end else if (deq) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        state_d = StPop;
                    end
                end
            end
            StIns: begin
                arr_d   = insert_key(arr_q, cnt_q, key_q);
                cnt_d   = cnt_q + 1'b1;
                state_d = StIdle;
            end
            StPop: begin
                arr_d   = pop_head(arr_q);
                cnt_d   = cnt_q - 1'b1;
                state_d = StIdle;
            end
            StRep: begin
                arr_d   = insert_key(pop_head(arr_q), cnt_q - 1'b1, key_q);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            arr_q   <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: tb/tb_pq_sorted_array.sv
// Directed bench for pq_sorted_array plus a random run against a sorted-queue model.
module tb_pq_sorted_array;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq = 1'b0;
    logic        deq = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        busy, full, empty, ovf, unf;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    logic        s_busy, s_ovf, s_unf;
    logic [3:0]  s_count;
    logic [15:0] m[$];

    pq_sorted_array #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .din(din), .dout(dout),
        .busy(busy), .full(full), .empty(empty), .count(count), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one command at cycle t; sample t+1 status, return at t+2 with result visible.
    task automatic do_cmd(input logic e, input logic d, input logic [15:0] k);
        enq = e;
        deq = d;
        din = k;
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
        s_busy  = busy;
        s_ovf   = ovf;
        s_unf   = unf;
        s_count = count;
        @(posedge clk);
        #1;
    endtask

    task automatic model_ins(input logic [15:0] k);
        int idx = m.size();
        for (int i = 0; i < m.size(); i++) begin
            if (m[i] > k) begin
                idx = i;
                break;
            end
        end
        m.insert(idx, k);
    endtask

    initial begin
        // Reset state.
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: async reset while INS is in flight.
        enq = 1'b1;
        din = 16'h0033;
        @(posedge clk);
        #1;
        enq = 1'b0;
        chk("t1_busy_ins", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t1_busy_rst", 32'(busy), 32'd0);
        chk("t1_count_rst", 32'(count), 32'd0);
        chk("t1_empty_rst", 32'(empty), 32'd1);
        chk("t1_dout_rst", 32'(dout), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        do_cmd(1'b1, 1'b0, 16'h0007);
        chk("t1_dout7", 32'(dout), 32'h7);
        chk("t1_count1", 32'(count), 32'd1);

        // 2: sorted insert then drain.
        do_reset();
        do_cmd(1'b1, 1'b0, 16'h0005);
        do_cmd(1'b1, 1'b0, 16'h0003);
        do_cmd(1'b1, 1'b0, 16'h0009);
        do_cmd(1'b1, 1'b0, 16'h0001);
        chk("t2_head", 32'(dout), 32'h1);
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_pop0", 32'(dout), 32'h1);
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t2_pop1", 32'(dout), 32'h3);
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t2_pop2", 32'(dout), 32'h5);
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t2_pop3", 32'(dout), 32'h9);
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t2_dout_end", 32'(dout), 32'h0);
        chk("t2_empty_end", 32'(empty), 32'd1);

        // 3: fill, overflow, then one deq.
        do_reset();
        for (int i = 0; i < 8; i++) do_cmd(1'b1, 1'b0, 16'h0010 + 16'(i));
        chk("t3_full", 32'(full), 32'd1);
        do_cmd(1'b1, 1'b0, 16'h0002);
        chk("t3_ovf_t1", 32'(s_ovf), 32'd1);
        chk("t3_busy_t1", 32'(s_busy), 32'd0);
        chk("t3_ovf_t2", 32'(ovf), 32'd0);
        chk("t3_dout", 32'(dout), 32'h10);
        chk("t3_count", 32'(count), 32'd8);
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t3_full_after", 32'(full), 32'd0);
        chk("t3_count_after", 32'(count), 32'd7);
        chk("t3_dout_after", 32'(dout), 32'h11);

        // 4: underflow.
        do_reset();
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t4_unf_t1", 32'(s_unf), 32'd1);
        chk("t4_busy_t1", 32'(s_busy), 32'd0);
        chk("t4_unf_t2", 32'(unf), 32'd0);
        chk("t4_dout", 32'(dout), 32'h0);
        chk("t4_count", 32'(count), 32'd0);

        // 5: replace.
        do_reset();
        do_cmd(1'b1, 1'b0, 16'h0002);
        do_cmd(1'b1, 1'b0, 16'h0004);
        do_cmd(1'b1, 1'b0, 16'h0006);
        do_cmd(1'b1, 1'b1, 16'h0005);
        chk("t5_count", 32'(count), 32'd3);
        chk("t5_pop0", 32'(dout), 32'h4);
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t5_pop1", 32'(dout), 32'h5);
        do_cmd(1'b0, 1'b1, 16'h0);
        chk("t5_pop2", 32'(dout), 32'h6);
        do_reset();
        for (int i = 0; i < 8; i++) do_cmd(1'b1, 1'b0, 16'h0010 + 16'(i));
        do_cmd(1'b1, 1'b1, 16'h0020);
        chk("t5_rep_ovf", 32'(s_ovf), 32'd0);
        chk("t5_rep_full", 32'(full), 32'd1);
        chk("t5_rep_count", 32'(count), 32'd8);
        chk("t5_rep_head", 32'(dout), 32'h11);

        // 6: held enq is accepted every other cycle.
        do_reset();
        enq = 1'b1;
        din = 16'h00AA;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_busy%0d", i), 32'(busy), 32'(i % 2));
            @(posedge clk);
            #1;
        end
        enq = 1'b0;
        chk("t6_count", 32'(count), 32'd2);
        chk("t6_dout", 32'(dout), 32'hAA);

        // 6: random ops against a sorted-queue model.
        do_reset();
        m.delete();
        for (int n = 0; n < 2000; n++) begin
            logic        e, d, x_ovf, x_unf;
            logic [15:0] k;
            logic [3:0]  pre;
            e     = 1'($urandom_range(0, 1));
            d     = 1'($urandom_range(0, 2) == 0);
            k     = 16'($urandom_range(0, 20));
            pre   = 4'(m.size());
            x_ovf = e && !d && (m.size() == 8);
            x_unf = d && !e && (m.size() == 0);
            if (e && d && m.size() != 0) begin
                void'(m.pop_front());
                model_ins(k);
            end else if (e && m.size() < 8) begin
                model_ins(k);
            end else if (d && !e && m.size() != 0) begin
                void'(m.pop_front());
            end
            do_cmd(e, d, k);
            chk("r_ovf", 32'(s_ovf), 32'(x_ovf));
            chk("r_unf", 32'(s_unf), 32'(x_unf));
            chk("r_count_busy", 32'(s_count), 32'(pre));
            chk("r_count", 32'(count), 32'(m.size()));
            chk("r_dout", 32'(dout), (m.size() != 0) ? 32'(m[0]) : 32'd0);
            chk("r_full", 32'(full), 32'(m.size() == 8));
            chk("r_empty", 32'(empty), 32'(m.size() == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
